// File: rtl/mux_sel_sequencer_pkg.sv
// mux_seq_pkg: shared types and defaults
// for the break-before-make select sequencer.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    SETTLE
  } state_t;

  // Flag stored beside the latched target index.
  localparam logic TGT_NONE  = 1'b1;
  localparam logic TGT_VALID = 1'b0;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_DEAD_CYC   = 2;
  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// mux_sel_sequencer_if: command strobe and
// select/status bundle of the sequencer.
interface mux_sel_sequencer_if #(
  parameter int N_CH = 4
);
  localparam int CW = $clog2(N_CH);

  logic          req;
  logic          off;
  logic [CW-1:0] ch;
  logic          busy;
  logic          done;
  logic          err;
  logic [N_CH-1:0] sel;
  logic [CW-1:0] cur_ch;
  logic          connected;

  modport master (
    output req, off, ch,
    input  busy, done, err,
    input  sel, cur_ch, connected
  );

  modport slave (
    input  req, off, ch,
    output busy, done, err,
    output sel, cur_ch, connected
  );
endinterface

// File: rtl/mux_sel_sequencer_onehot_dec.sv
// onehot_dec: binary index to one-hot.
// Out-of-range indices decode to all zeros.
module onehot_dec #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] oh
);

  // Compare the index against every output position.
  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++) begin
      oh[i] = (idx == W'(i));
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: break-before-make select
// driver with dead time and settle time.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DEAD_CYC   = DEF_DEAD_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  mux_sel_sequencer_if.slave bus
);

  localparam int CW = $clog2(N_CH);
  localparam logic [CNT_W-1:0] DEAD_LD =
    CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYC - 1);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tgt_q, tgt_d;
  logic none_q, none_d;

  logic [N_CH-1:0] sel_q, sel_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic [CW-1:0] cur_q, cur_d;
  logic conn_q, conn_d;

  logic ch_ok;
  logic cnt_zero;
  logic go_off, go_conn;
  logic go_same, go_err;
  logic [N_CH-1:0] tgt_oh;

  // Indices past N_CH exist only for
  // non-power-of-two channel counts.
  if (N_CH == (1 << CW)) begin : g_pow2
    assign ch_ok = 1'b1;
  end else begin : g_npow2
    assign ch_ok = (bus.ch < CW'(N_CH));
  end

  onehot_dec #(
    .N (N_CH),
    .W (CW)
  ) u_dec (
    .idx (tgt_q),
    .oh  (tgt_oh)
  );

  assign cnt_zero = (cnt_q == '0);

  // Classify an IDLE request.
  always_comb begin
    go_off  = bus.req & bus.off;
    go_conn = 1'b0;
    go_same = 1'b0;
    go_err  = 1'b0;
    if (bus.req && !bus.off) begin
      go_err  = !ch_ok;
      go_same = ch_ok & conn_q &
                (bus.ch == cur_q);
      go_conn = ch_ok & !go_same;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      none_q  <= TGT_VALID;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cur_q   <= '0;
      conn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      none_q  <= none_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cur_q   <= cur_d;
      conn_q  <= conn_d;
    end
  end

  // Next state, dead/settle counter, target latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    none_d  = none_q;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          go_off: begin
            state_d = DEAD;
            cnt_d   = DEAD_LD;
            none_d  = TGT_NONE;
          end
          go_conn: begin
            state_d = DEAD;
            cnt_d   = DEAD_LD;
            tgt_d   = bus.ch;
            none_d  = TGT_VALID;
          end
          default: ;
        endcase
      end
      DEAD: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (none_q == TGT_NONE) begin
          state_d = IDLE;
        end else begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    sel_d  = sel_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    cur_d  = cur_q;
    conn_d = conn_q;
    case (state_q)
      IDLE: begin
        unique case (1'b1)
          go_off: begin
            sel_d  = '0;
            conn_d = 1'b0;
            busy_d = 1'b1;
          end
          go_conn: begin
            sel_d  = '0;
            conn_d = 1'b0;
            busy_d = 1'b1;
          end
          go_same: done_d = 1'b1;
          go_err:  err_d  = 1'b1;
          default: ;
        endcase
      end
      DEAD: begin
        if (cnt_zero) begin
          if (none_q == TGT_NONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            sel_d  = tgt_oh;
            cur_d  = tgt_q;
            conn_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cur_ch    = cur_q;
  assign bus.connected = conn_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: timeline model check
// of the select sequencer, plus pinned cases.
module tb_mux_sel_sequencer;

  localparam int D = 2;
  localparam int S = 4;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.N_CH(4)) bus4 ();
  mux_sel_sequencer_if #(.N_CH(3)) bus3 ();

  mux_sel_sequencer #(.N_CH(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux_sel_sequencer #(.N_CH(3)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Model: a command is an acceptance edge plus
  // a kind; outputs follow from elapsed edges.
  int  cyc = 0;
  bit  m_act, m_off, m_conn, m_done, m_err;
  int  m_t0, m_tgt, m_cur, el;
  logic [N-1:0] prev_sel = '0;
  logic [N-1:0] exp_sel;

  always @(posedge clk) begin
    logic r, o;
    int c;
    r = bus4.req;
    o = bus4.off;
    c = int'(bus4.ch);
    cyc++;
    m_done = 0;
    m_err  = 0;
    if (!rst_n) begin
      m_act = 0; m_off = 0;
      m_conn = 0; m_cur = 0;
    end else if (m_act) begin
      el = cyc - m_t0;
      if (!m_off && el == D) begin
        m_conn = 1;
        m_cur  = m_tgt;
      end
      if (el == (m_off ? D : D + S)) begin
        m_done = 1;
        m_act  = 0;
      end
    end else if (r) begin
      if (o) begin
        m_act = 1; m_off = 1;
        m_t0 = cyc; m_conn = 0;
      end else if (c >= N) begin
        m_err = 1;
      end else if (m_conn && c == m_cur) begin
        m_done = 1;
      end else begin
        m_act = 1; m_off = 0;
        m_t0 = cyc; m_tgt = c;
        m_conn = 0;
      end
    end
    exp_sel = m_conn ? N'(1 << m_cur) : '0;
    #1;
    chk("busy", 32'(bus4.busy), 32'(m_act));
    chk("done", 32'(bus4.done), 32'(m_done));
    chk("err", 32'(bus4.err), 32'(m_err));
    chk("sel", 32'(bus4.sel), 32'(exp_sel));
    chk("connected", 32'(bus4.connected),
        32'(m_conn));
    if (m_conn)
      chk("cur_ch", 32'(bus4.cur_ch),
          32'(m_cur));
    chk("sel_onehot0", 32'($onehot0(bus4.sel)), 1);
    chk("sel_bbm", 32'(prev_sel == '0 ||
        bus4.sel == '0 || bus4.sel == prev_sel), 1);
    prev_sel = bus4.sel;
  end

  task automatic nwait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic o,
                       input logic [1:0] c);
    bus4.req = 1'b1;
    bus4.off = o;
    bus4.ch  = c;
    @(negedge clk);
    bus4.req = 1'b0;
    bus4.off = 1'b0;
  endtask

  initial begin
    bus4.req = 0; bus4.off = 0; bus4.ch = '0;
    bus3.req = 0; bus3.off = 0; bus3.ch = '0;
    nwait(3);
    rst_n = 1'b1;
    chk("rst_sel", 32'(bus4.sel), 0);
    chk("rst_busy", 32'(bus4.busy), 0);
    nwait(20);

    // N_CH=3: connect ch1, then ch3 is rejected.
    bus3.req = 1; bus3.ch = 2'd1;
    @(negedge clk);
    bus3.req = 0;
    nwait(6);
    chk("n3_done", 32'(bus3.done), 1);
    chk("n3_sel", 32'(bus3.sel), 32'h2);
    bus3.req = 1; bus3.ch = 2'd3;
    @(negedge clk);
    bus3.req = 0;
    chk("n3_err", 32'(bus3.err), 1);
    chk("n3_err_sel", 32'(bus3.sel), 32'h2);
    chk("n3_err_busy", 32'(bus3.busy), 0);
    nwait(1);
    chk("n3_err_pulse", 32'(bus3.err), 0);
    chk("n3_conn", 32'(bus3.connected), 1);

    // Connect ch2 from idle.
    issue(0, 2);
    chk("c2_sel_k", 32'(bus4.sel), 0);
    chk("c2_busy_k", 32'(bus4.busy), 1);
    nwait(1);
    chk("c2_sel_k1", 32'(bus4.sel), 0);
    nwait(1);
    chk("c2_sel_k2", 32'(bus4.sel), 32'h4);
    nwait(3);
    chk("c2_done_k5", 32'(bus4.done), 0);
    chk("c2_busy_k5", 32'(bus4.busy), 1);
    nwait(1);
    chk("c2_done_k6", 32'(bus4.done), 1);
    chk("c2_busy_k6", 32'(bus4.busy), 0);

    // Switch 2 -> 1.
    issue(0, 1);
    chk("sw_sel_k", 32'(bus4.sel), 0);
    nwait(1);
    chk("sw_sel_k1", 32'(bus4.sel), 0);
    nwait(1);
    chk("sw_sel_k2", 32'(bus4.sel), 32'h2);
    nwait(4);
    chk("sw_done", 32'(bus4.done), 1);

    // Same channel, then off.
    issue(0, 1);
    chk("same_done", 32'(bus4.done), 1);
    chk("same_busy", 32'(bus4.busy), 0);
    chk("same_sel", 32'(bus4.sel), 32'h2);
    nwait(1);
    issue(1, 0);
    chk("off_sel", 32'(bus4.sel), 0);
    chk("off_conn", 32'(bus4.connected), 0);
    nwait(1);
    chk("off_done_k1", 32'(bus4.done), 0);
    nwait(1);
    chk("off_done_k2", 32'(bus4.done), 1);

    // Requests while busy are dropped.
    issue(0, 3);
    for (int i = 0; i < 3; i++) begin
      bus4.req = 1'b1;
      bus4.off = 1'($urandom_range(0, 1));
      bus4.ch  = 2'($urandom_range(0, 2));
      @(negedge clk);
    end
    bus4.req = 1'b0;
    bus4.off = 1'b0;
    chk("bz_busy", 32'(bus4.busy), 1);
    nwait(2);
    chk("bz_done_k5", 32'(bus4.done), 0);
    nwait(1);
    chk("bz_done_k6", 32'(bus4.done), 1);
    chk("bz_sel", 32'(bus4.sel), 32'h8);

    // Reset in the middle of SETTLE.
    issue(0, 0);
    nwait(3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel", 32'(bus4.sel), 0);
    chk("ar_busy", 32'(bus4.busy), 0);
    chk("ar_conn", 32'(bus4.connected), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nwait(10);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus4.req = ($urandom_range(0, 2) == 0);
      bus4.off = ($urandom_range(0, 4) == 0);
      bus4.ch  = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus4.req = 1'b0;
    nwait(12);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
